rr_arb_mux: RTL and testbench

//   Registered N:1 data multiplexer with built-in arbitration. It is the successor to
//   the fixed 4:1 select mux.
//   - Each of N producer channels presents WIDTH-bit data with a valid/ready handshake.
//   - The block picks one requesting channel per cycle, round-robin or fixed priority.
//   - The chosen word is registered into a single output stage.
//   - Used where several pipeline sources (e.g. writeback/forwarding sources) share one

---
 rtl/rr_arb_mux.sv | 79 +++++++
 tb/tb_rr_arb_mux.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - registered N:1 data mux with round-robin or fixed-priority arbitration
module rr_arb_mux #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    start;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    gnt;
    logic [WIDTH-1:0] sel_data;
    logic             found;
    logic             load;
    logic             take;

    // Search requests from the start index upward with modulo-N wrap; first hit wins.
    always_comb begin
        start    = (MODE == 0) ? ptr : '0;
        cand     = '0;
        gnt      = '0;
        sel_data = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = start + IW'(i);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (gnt == IW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage may accept a new word when empty or being drained this cycle.
    always_comb begin
        load     = !out_valid || out_ready;
        take     = load && found && !reset;
        in_ready = '0;
        if (take) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // Output register and priority pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_idx <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            grant_idx <= gnt;
            if (MODE == 0) begin
                ptr <= gnt + 1'b1;
            end
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed table-driven bench for rr_arb_mux in both arbitration modes
module tb_rr_arb_mux;

    localparam int WIDTH = 64;
    localparam int N     = 4;

    localparam logic [63:0] C0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] C2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] C3 = 64'hDEAD_BEEF_CAFE_F00D;

    typedef struct {
        logic        m;
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_gi;
        logic [63:0] exp_data;
    } vec_t;

    logic               clk;
    logic               reset;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic               out_ready;

    logic [N-1:0]     rdy0, rdy1;
    logic             ov0, ov1;
    logic [WIDTH-1:0] od0, od1;
    logic [1:0]       gi0, gi1;

    int checks;
    int failures;
    vec_t tbl[$];
    logic [63:0] chdat[4];

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .grant_idx(gi0)
    );

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .grant_idx(gi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int row, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic rst, input logic [3:0] valid,
                                input logic ordy, input logic [3:0] exp_rdy,
                                input logic exp_ov, input logic [1:0] exp_gi,
                                input logic [63:0] exp_data);
        vec_t v;
        v.m = m; v.rst = rst; v.valid = valid; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_gi = exp_gi; v.exp_data = exp_data;
        return v;
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        chdat[0] = C0; chdat[1] = C1; chdat[2] = C2; chdat[3] = C3;
        in_data   = {C3, C2, C1, C0};

        // Round-robin rotation with every channel requesting: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(0, 0, 4'b1111, 1, 4'(1 << (k % 4)), 1, 2'(k % 4), chdat[k % 4]));
        end
        // Put ptr at 3, then wrap/skip over idle channels.
        tbl.push_back(mk(0, 0, 4'b0100, 1, 4'b0100, 1, 2, C2));
        tbl.push_back(mk(0, 0, 4'b0101, 1, 4'b0001, 1, 0, C0));
        tbl.push_back(mk(0, 0, 4'b0101, 1, 4'b0100, 1, 2, C2));
        tbl.push_back(mk(0, 0, 4'b0101, 1, 4'b0001, 1, 0, C0));
        // Drain: valid drops, data and index retained.
        tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, C0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, C0));
        // Stall for five cycles, then same-cycle refill.
        tbl.push_back(mk(0, 0, 4'b1111, 0, 4'b0010, 1, 1, C1));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(0, 0, 4'b1111, 0, 4'b0000, 1, 1, C1));
        end
        tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0100, 1, 2, C2));
        tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b1000, 1, 3, C3));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 3, C3));
        // Fixed priority instance.
        tbl.push_back(mk(1, 1, 4'b1111, 1, 4'b0000, 0, 0, 64'h0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 0, 4'b1110, 1, 4'b0010, 1, 1, C1));
        end
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0, C0));
        end
        tbl.push_back(mk(1, 0, 4'b1111, 0, 4'b0000, 1, 0, C0));
        tbl.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 0, 0, C0));

        // Reset with all channels requesting: nothing is taken.
        @(negedge clk);
        reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        #1;
        check("reset_in_ready", -1, 64'(rdy0), 64'h0);
        @(posedge clk); #1;
        check("reset_out_valid", -1, 64'(ov0), 64'h0);
        check("reset_out_data", -1, od0, 64'h0);
        check("reset_grant_idx", -1, 64'(gi0), 64'h0);

        // Load a word, stall it, then advance ptr before a mid-operation reset.
        reset = 1'b0;
        #1;
        check("load_in_ready", -2, 64'(rdy0), 64'h1);
        @(posedge clk); #1;
        check("load_out_data", -2, od0, C0);
        check("load_out_valid", -2, 64'(ov0), 64'h1);
        reset = 1'b1;
        #1;
        check("midreset_in_ready", -3, 64'(rdy0), 64'h0);
        @(posedge clk); #1;
        check("midreset_out_valid", -3, 64'(ov0), 64'h0);
        check("midreset_out_data", -3, od0, 64'h0);
        check("midreset_grant_idx", -3, 64'(gi0), 64'h0);
        reset = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            reset     = tbl[r].rst;
            in_valid  = tbl[r].valid;
            out_ready = tbl[r].ordy;
            #1;
            check("in_ready", r, 64'(tbl[r].m ? rdy1 : rdy0), 64'(tbl[r].exp_rdy));
            @(posedge clk); #1;
            check("out_valid", r, 64'(tbl[r].m ? ov1 : ov0), 64'(tbl[r].exp_ov));
            check("grant_idx", r, 64'(tbl[r].m ? gi1 : gi0), 64'(tbl[r].exp_gi));
            check("out_data", r, tbl[r].m ? od1 : od0, tbl[r].exp_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
